cpu_io_unit: RTL and testbench
==============================

# cpu_io_unit

Buffered, word-width I/O unit between the multicycle core and the UART byte receiver/sender. It replaces the byte-at-a-time `in`/`out` stall loop with parametrised RX and TX FIFOs. Core commands move 1 to DATA_W/8 bytes per instruction, little-endian. TX drain to the sender runs independently of the core.

## Interface
Parameters:
- DATA_W, 32, core word width; a multiple of 8, from 8 to 64.
- RX_DEPTH, 16, RX FIFO entries (bytes); a power of 2, at least 2.
- TX_DEPTH, 16, TX FIFO entries (bytes); a power of 2, at least 2.
- NB_W = $clog2(DATA_W/8)+1 (derived, localparam).

Ports. One clock; reset is asynchronous and active-low:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the receiver.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- tx_data  out  8  byte to the sender.
- tx_start  out  1  one-cycle strobe: start sending tx_data.
- tx_busy  in  1  sender is transmitting.
- cmd_valid  in  1  core requests an operation.
- cmd_ready  out  1  unit is idle and accepts a command.
- cmd_op  in  1  operation: 0 = IN, 1 = OUT.
- cmd_nbytes  in  NB_W  byte count.
- cmd_wdata  in  DATA_W  OUT data; captured when the command is accepted.
- rdata  out  DATA_W  IN result.
- done  out  1  one-cycle strobe: command finished.
- rx_count  out  $clog2(RX_DEPTH)+1  current RX FIFO occupancy.
- tx_count  out  $clog2(TX_DEPTH)+1  current TX FIFO occupancy.
- rx_overflow  out  1  sticky flag: an RX byte was dropped.
- clr_ovf  in  1  clears rx_overflow.

## Operation
- **Command accept:** a command is accepted on a cycle where cmd_valid and cmd_ready are both 1. At that point cmd_op, the effective byte count N and cmd_wdata are latched.
- **Byte count:** N = cmd_nbytes. If cmd_nbytes is 0 or greater than DATA_W/8, N = DATA_W/8.
- **Core FSM states:**
  - IDLE: cmd_ready=1. On accept, go to IN_POP (op 0) or OUT_PUSH (op 1).
  - IN_POP: each cycle the RX FIFO is non-empty, pop one byte into byte lane k of an assembly register (k = 0..N-1). Lanes N and above are zero. After the N-th pop, go to DONE. An empty FIFO stalls without limit.
  - OUT_PUSH: each cycle the TX FIFO is not full, push byte lane k of the latched wdata (LSB first). After the N-th push, go to DONE.
  - DONE: done=1 for one cycle. For IN, rdata is loaded with the assembled word in this cycle. Then go to IDLE.
- **rdata:** holds its value until the next IN reaches DONE. OUT commands never change rdata.
- **RX FIFO push:** every rx_valid pushes rx_data.
  - If the FIFO is full with no pop in the same cycle, the byte is dropped and rx_overflow is set to 1.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted.
- **rx_overflow:** clr_ovf clears it. If clr_ovf and a drop occur in the same cycle, rx_overflow stays 1 (set wins).
- **No bypass:** a byte pushed while the RX FIFO is empty can be popped on the next cycle at the earliest.
- **TX drain FSM** (independent of the core FSM):
  - TX_IDLE: when the TX FIFO is non-empty and tx_busy=0, pop the head, drive it on tx_data, pulse tx_start, and go to TX_GUARD.
  - TX_GUARD: one cycle; tx_busy is ignored. Go to TX_WAIT.
  - TX_WAIT: stay while tx_busy=1. On tx_busy=0, go to TX_IDLE.
- **Simultaneous TX push and pop:** core pushes and drain pops in the same cycle are both honoured, and tx_count is unchanged.
- **FIFO pointers:** FIFOs use wrapping pointers with one extra bit for the full/empty distinction. Counts equal the pointer difference.

## Timing
- **Reset values:** cmd_ready=1, done=0, rdata=0, tx_data=0, tx_start=0, rx_count=0, tx_count=0, rx_overflow=0. Both FSMs are in IDLE and both FIFOs are empty.
- **Reset mid-operation:** rstn low immediately discards FIFO contents and any in-flight command. No done or tx_start is issued after reset.
- **IN latency, bytes present:** accept at cycle 0, pops in cycles 1..N, done in cycle N+1, cmd_ready=1 in cycle N+2. Each cycle with an empty FIFO adds one cycle.
- **OUT latency:** the same shape. done means the bytes are queued, not sent.
- **tx_data:** stable from the tx_start cycle until the next tx_start.
- **Send spacing:** there is a minimum of 3 cycles between successive tx_start pulses (IDLE, GUARD, at least one WAIT cycle).
- **Status outputs:** rx_count and tx_count are registered and reflect pushes and pops from the previous cycle.

## Test plan
- **Reset values:** assert rstn low mid-IN with 3 bytes in the RX FIFO, then release → rx_count=0, cmd_ready=1, rdata=0, no done pulse.
- **IN 4 bytes:** send rx bytes 0x11, 0x22, 0x33, 0x44, then IN with N=4 → done 5 cycles after accept, rdata=0x44332211.
- **IN 2 bytes, late data:** IN with N=2 on an empty FIFO, then 0xAB on cycle 10 and 0xCD on cycle 20 → rdata=0x0000CDAB, done on cycle 22.
- **RX overflow:** push RX_DEPTH+1 bytes with no pops → rx_count=RX_DEPTH, rx_overflow=1, and the last byte is dropped. Assert clr_ovf in the same cycle as another drop → rx_overflow stays 1.
- **OUT with sender backpressure:** OUT 0xDEADBEEF with N=4 and a sender model holding tx_busy high for 10 cycles after each tx_start → tx_start bytes in order EF, BE, AD, DE, and done 5 cycles after accept.
- **TX full and N=0 saturation:** TX_DEPTH=2 with tx_busy held high, OUT with N=0 (saturates to 4) → cmd_ready stays 0 until tx_busy drops, then done follows and all 4 bytes are eventually sent.

Source files
------------

// File: rtl/cpu_io_unit.sv
// Word-wide core I/O unit: RX/TX byte FIFOs between the core and the UART,
// with a core command FSM and an independent TX drain FSM.
//
// state      | meaning
// S_IDLE     | cmd_ready=1, waiting for a command
// S_IN_POP   | popping N RX bytes into the assembly word, LSB first
// S_OUT_PUSH | pushing N bytes of the latched word into the TX FIFO
// S_DONE     | one-cycle done strobe
// T_IDLE     | waiting for a queued byte and an idle sender
// T_GUARD    | one cycle after tx_start, tx_busy not yet meaningful
// T_WAIT     | waiting for the sender to finish
module cpu_io_unit #(
   parameter int DATA_W   = 32,
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic [7:0]                    tx_data,
   output logic                          tx_start,
   input  logic                          tx_busy,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_op,
   input  logic [$clog2(DATA_W/8):0]     cmd_nbytes,
   input  logic [DATA_W-1:0]             cmd_wdata,
   output logic [DATA_W-1:0]             rdata,
   output logic                          done,
   output logic [$clog2(RX_DEPTH):0]     rx_count,
   output logic [$clog2(TX_DEPTH):0]     tx_count,
   output logic                          rx_overflow,
   input  logic                          clr_ovf
);
   localparam int NBYTES = DATA_W / 8;
   localparam int NB_W   = $clog2(NBYTES) + 1;
   localparam int RA_W   = $clog2(RX_DEPTH);
   localparam int TA_W   = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_IN_POP, S_OUT_PUSH, S_DONE} core_state_e;
   typedef enum logic [1:0] {T_IDLE, T_GUARD, T_WAIT} tx_state_e;

   core_state_e         state_q, state_d;
   tx_state_e           txs_q, txs_d;
   logic                op_q, op_d;
   logic [NB_W-1:0]     n_q, n_d, k_q, k_d, n_eff;
   logic [DATA_W-1:0]   wdata_q, wdata_d, asm_q, asm_d, rdata_q, rdata_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                ovf_q, ovf_d;

   logic [7:0]          rx_mem_q [RX_DEPTH];
   logic [RA_W:0]       rx_wptr_q, rx_rptr_q;
   logic                rx_push, rx_pop, rx_empty, rx_full, rx_drop;
   logic [7:0]          rx_head;

   logic [7:0]          tx_mem_q [TX_DEPTH];
   logic [TA_W:0]       tx_wptr_q, tx_rptr_q;
   logic                tx_push, tx_pop, tx_empty, tx_full;
   logic [7:0]          tx_head;

   assign rx_count = rx_wptr_q - rx_rptr_q;
   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == (RA_W+1)'(RX_DEPTH));
   assign rx_head  = rx_mem_q[rx_rptr_q[RA_W-1:0]];
   // A full FIFO still takes a byte when the core pops in the same cycle.
   assign rx_push  = rx_valid && (!rx_full || rx_pop);
   assign rx_drop  = rx_valid && rx_full && !rx_pop;
   assign ovf_d    = rx_drop | (ovf_q & ~clr_ovf);

   assign tx_count = tx_wptr_q - tx_rptr_q;
   assign tx_empty = (tx_count == '0);
   assign tx_full  = (tx_count == (TA_W+1)'(TX_DEPTH));
   assign tx_head  = tx_mem_q[tx_rptr_q[TA_W-1:0]];

   assign rdata       = rdata_q;
   assign rx_overflow = ovf_q;
   assign tx_start    = tx_pop;
   assign tx_data     = tx_pop ? tx_head : tx_data_q;

   always_comb begin
      n_eff = cmd_nbytes;
      if (cmd_nbytes == '0 || cmd_nbytes > NB_W'(NBYTES)) n_eff = NB_W'(NBYTES);
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      n_d       = n_q;
      k_d       = k_q;
      wdata_d   = wdata_q;
      asm_d     = asm_q;
      rdata_d   = rdata_q;
      rx_pop    = 1'b0;
      tx_push   = 1'b0;
      cmd_ready = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               n_d     = n_eff;
               k_d     = '0;
               wdata_d = cmd_wdata;
               asm_d   = '0;
               state_d = cmd_op ? S_OUT_PUSH : S_IN_POP;
            end
         end
         S_IN_POP: begin
            if (!rx_empty) begin
               rx_pop = 1'b1;
               asm_d  = asm_q | (DATA_W'(rx_head) << (8 * k_q));
               k_d    = k_q + NB_W'(1);
               if (k_q == n_q - NB_W'(1)) begin
                  rdata_d = asm_d;
                  state_d = S_DONE;
               end
            end
         end
         S_OUT_PUSH: begin
            if (!tx_full) begin
               tx_push = 1'b1;
               wdata_d = wdata_q >> 8;
               k_d     = k_q + NB_W'(1);
               if (k_q == n_q - NB_W'(1)) state_d = S_DONE;
            end
         end
         default: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      txs_d     = txs_q;
      tx_pop    = 1'b0;
      tx_data_d = tx_data_q;
      case (txs_q)
         T_IDLE: begin
            if (!tx_empty && !tx_busy) begin
               tx_pop    = 1'b1;
               tx_data_d = tx_head;
               txs_d     = T_GUARD;
            end
         end
         T_GUARD: txs_d = T_WAIT;
         default: if (!tx_busy) txs_d = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wptr_q[RA_W-1:0]] <= rx_data;
      if (tx_push) tx_mem_q[tx_wptr_q[TA_W-1:0]] <= wdata_q[7:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         txs_q     <= T_IDLE;
         op_q      <= 1'b0;
         n_q       <= '0;
         k_q       <= '0;
         wdata_q   <= '0;
         asm_q     <= '0;
         rdata_q   <= '0;
         tx_data_q <= '0;
         ovf_q     <= 1'b0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
      end else begin
         state_q   <= state_d;
         txs_q     <= txs_d;
         op_q      <= op_d;
         n_q       <= n_d;
         k_q       <= k_d;
         wdata_q   <= wdata_d;
         asm_q     <= asm_d;
         rdata_q   <= rdata_d;
         tx_data_q <= tx_data_d;
         ovf_q     <= ovf_d;
         if (rx_push) rx_wptr_q <= rx_wptr_q + (RA_W+1)'(1);
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + (RA_W+1)'(1);
         if (tx_push) tx_wptr_q <= tx_wptr_q + (TA_W+1)'(1);
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + (TA_W+1)'(1);
      end
   end
endmodule

// File: tb/tb_cpu_io_unit.sv
// Bench for cpu_io_unit: byte-queue reference model for RX, sender model with
// configurable busy hold, and a second instance with a 2-entry TX FIFO.
module tb_cpu_io_unit;
   localparam int DATA_W   = 32;
   localparam int RX_DEPTH = 16;
   localparam int TX_DEPTH = 16;
   localparam int NB_W     = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstn;
   logic [7:0]        rx_data, tx_data;
   logic              rx_valid, tx_start;
   logic              tx_busy = 1'b0;
   logic              cmd_valid, cmd_ready, cmd_op, done, rx_overflow, clr_ovf;
   logic [NB_W-1:0]   cmd_nbytes;
   logic [31:0]       cmd_wdata, rdata;
   logic [4:0]        rx_count, tx_count;

   logic [7:0]        d2_tx_data;
   logic              d2_tx_start, d2_busy, d2_valid, d2_ready, d2_op, d2_done, d2_ovf;
   logic [NB_W-1:0]   d2_nb;
   logic [31:0]       d2_wd, d2_rdata;
   logic [4:0]        d2_rx_count;
   logic [1:0]        d2_tx_count;

   cpu_io_unit #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
      .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_nbytes(cmd_nbytes), .cmd_wdata(cmd_wdata), .rdata(rdata), .done(done),
      .rx_count(rx_count), .tx_count(tx_count), .rx_overflow(rx_overflow),
      .clr_ovf(clr_ovf));

   cpu_io_unit #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(2)) dut2 (
      .clk(clk), .rstn(rstn), .rx_data(8'h00), .rx_valid(1'b0),
      .tx_data(d2_tx_data), .tx_start(d2_tx_start), .tx_busy(d2_busy),
      .cmd_valid(d2_valid), .cmd_ready(d2_ready), .cmd_op(d2_op),
      .cmd_nbytes(d2_nb), .cmd_wdata(d2_wd), .rdata(d2_rdata), .done(d2_done),
      .rx_count(d2_rx_count), .tx_count(d2_tx_count), .rx_overflow(d2_ovf),
      .clr_ovf(1'b0));

   int errors = 0, checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   byte unsigned rxq[$];
   logic         model_ovf = 1'b0;
   logic [31:0]  last_rdata = '0;

   byte unsigned tx_log[$], tx2_log[$];
   int           tx_cyc[$];
   int           hold_cycles = 10, busy_cnt = 0, done_cnt = 0;
   logic         snd_st;

   // Sender model: observe strobes mid-cycle, raise tx_busy just after the next edge.
   always begin
      @(negedge clk);
      snd_st = tx_start;
      if (tx_start) begin tx_log.push_back(tx_data); tx_cyc.push_back(cyc); end
      if (d2_tx_start) tx2_log.push_back(d2_tx_data);
      if (done) done_cnt++;
      @(posedge clk); #1;
      if (snd_st) busy_cnt = hold_cycles;
      if (busy_cnt > 0) begin tx_busy = 1'b1; busy_cnt--; end
      else tx_busy = 1'b0;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      if (rxq.size() < RX_DEPTH) rxq.push_back(b); else model_ovf = 1'b1;
   endtask

   function automatic logic [31:0] take(input int n);
      logic [31:0] w = '0;
      for (int i = 0; i < n; i++) w[8*i +: 8] = rxq.pop_front();
      return w;
   endfunction

   function automatic int eff_n(input int nb);
      return (nb == 0 || nb > 4) ? 4 : nb;
   endfunction

   task automatic issue(input logic op, input int nb, input logic [31:0] wd);
      cmd_op = op; cmd_nbytes = NB_W'(nb); cmd_wdata = wd; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_nbytes = NB_W'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 300; c++) begin
         if (done) begin lat = c; break; end
         step();
      end
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      repeat (2) step();
      rstn = 1'b1;
      rxq.delete(); model_ovf = 1'b0; last_rdata = '0;
      step();
   endtask

   task automatic test_reset();
      int lat, dc;
      checks += 8;
      if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
      if (done !== 1'b0)       begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      if (rdata !== 32'h0)     begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      if (tx_data !== 8'h0)    begin errors++; $display("FAIL rst_tx_data got=%h exp=0", tx_data); end
      if (tx_start !== 1'b0)   begin errors++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
      if (rx_count !== 5'd0)   begin errors++; $display("FAIL rst_rx_count got=%0d exp=0", rx_count); end
      if (tx_count !== 5'd0)   begin errors++; $display("FAIL rst_tx_count got=%0d exp=0", tx_count); end
      if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", rx_overflow); end
      rstn = 1'b1;
      step();
      push_rx(8'h5A);
      issue(1'b0, 1, '0);
      wait_done(lat);
      step();
      last_rdata = take(1);
      checks++;
      if (rdata !== last_rdata) begin errors++; $display("FAIL pre_rst_rdata got=%h exp=%h", rdata, last_rdata); end
      for (int i = 0; i < 3; i++) push_rx(8'($urandom));
      checks++;
      if (rx_count !== 5'd3) begin errors++; $display("FAIL pre_rst_rx_count got=%0d exp=3", rx_count); end
      dc = done_cnt;
      issue(1'b0, 4, '0);
      rstn = 1'b0;
      repeat (2) step();
      rstn = 1'b1;
      rxq.delete(); last_rdata = '0;
      repeat (8) step();
      checks += 4;
      if (rx_count !== 5'd0)  begin errors++; $display("FAIL midrst_rx_count got=%0d exp=0", rx_count); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready got=%b exp=1", cmd_ready); end
      if (rdata !== 32'h0)    begin errors++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
      if (done_cnt !== dc)    begin errors++; $display("FAIL midrst_done got=%0d pulses exp=%0d", done_cnt, dc); end
   endtask

   task automatic test_in_4();
      int lat;
      push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
      issue(1'b0, 4, '0);
      wait_done(lat);
      step();
      void'(take(4));
      last_rdata = 32'h44332211;
      checks += 3;
      if (lat !== 5) begin errors++; $display("FAIL in4_latency got=%0d exp=5", lat); end
      if (rdata !== 32'h44332211) begin errors++; $display("FAIL in4_rdata got=%h exp=44332211", rdata); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL in4_ready_after got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_in_late();
      int lat = -1;
      issue(1'b0, 2, '0);
      for (int c = 1; c <= 25; c++) begin
         rx_valid = (c == 10 || c == 20);
         rx_data  = (c == 10) ? 8'hAB : 8'hCD;
         if (done && lat < 0) lat = c;
         step();
      end
      rx_valid = 1'b0;
      last_rdata = 32'h0000CDAB;
      checks += 2;
      if (lat !== 22) begin errors++; $display("FAIL late_latency got=%0d exp=22", lat); end
      if (rdata !== 32'h0000CDAB) begin errors++; $display("FAIL late_rdata got=%h exp=0000cdab", rdata); end
   endtask

   task automatic test_in_random();
      int lat, nb, n, pre;
      logic [31:0] exp;
      for (int it = 0; it < 6; it++) begin
         nb  = $urandom_range(0, 7);
         n   = eff_n(nb);
         pre = (n > rxq.size() ? n - rxq.size() : 0) + $urandom_range(0, 1);
         for (int i = 0; i < pre; i++) push_rx(8'($urandom));
         exp = take(n);
         issue(1'b0, nb, $urandom);
         wait_done(lat);
         step();
         last_rdata = exp;
         checks += 3;
         if (lat !== n + 1) begin errors++; $display("FAIL inr_latency nb=%0d got=%0d exp=%0d", nb, lat, n + 1); end
         if (rdata !== exp) begin errors++; $display("FAIL inr_rdata nb=%0d got=%h exp=%h", nb, rdata, exp); end
         if (rx_count !== 5'(rxq.size())) begin errors++; $display("FAIL inr_rx_count got=%0d exp=%0d", rx_count, rxq.size()); end
      end
   endtask

   task automatic test_overflow();
      int lat;
      byte unsigned b;
      logic [31:0] exp;
      apply_reset();
      for (int i = 0; i <= RX_DEPTH; i++) push_rx(8'($urandom));
      checks += 2;
      if (rx_count !== 5'(RX_DEPTH)) begin errors++; $display("FAIL ovf_rx_count got=%0d exp=%0d", rx_count, RX_DEPTH); end
      if (rx_overflow !== model_ovf) begin errors++; $display("FAIL ovf_set got=%b exp=%b", rx_overflow, model_ovf); end
      rx_valid = 1'b1; rx_data = 8'hEE; clr_ovf = 1'b1;
      step();
      rx_valid = 1'b0;
      model_ovf = (rxq.size() == RX_DEPTH) ? 1'b1 : 1'b0;
      checks++;
      if (rx_overflow !== model_ovf) begin errors++; $display("FAIL ovf_set_wins got=%b exp=%b", rx_overflow, model_ovf); end
      step();
      clr_ovf = 1'b0;
      model_ovf = 1'b0;
      checks++;
      if (rx_overflow !== model_ovf) begin errors++; $display("FAIL ovf_clear got=%b exp=%b", rx_overflow, model_ovf); end
      issue(1'b0, 1, '0);
      b = 8'($urandom);
      rx_data = b; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      exp = take(1);
      rxq.push_back(b);
      checks += 2;
      if (rx_count !== 5'(RX_DEPTH)) begin errors++; $display("FAIL full_pop_count got=%0d exp=%0d", rx_count, RX_DEPTH); end
      if (rx_overflow !== 1'b0) begin errors++; $display("FAIL full_pop_ovf got=%b exp=0", rx_overflow); end
      step();
      last_rdata = exp;
      checks++;
      if (rdata !== exp) begin errors++; $display("FAIL full_pop_rdata got=%h exp=%h", rdata, exp); end
      for (int w = 0; w < RX_DEPTH / 4; w++) begin
         exp = take(4);
         issue(1'b0, 4, '0);
         wait_done(lat);
         step();
         last_rdata = exp;
         checks++;
         if (rdata !== exp) begin errors++; $display("FAIL ovf_drain_word%0d got=%h exp=%h", w, rdata, exp); end
      end
      checks++;
      if (rx_count !== 5'd0) begin errors++; $display("FAIL ovf_drained_count got=%0d exp=0", rx_count); end
   endtask

   task automatic test_out_backpressure();
      int lat, t;
      logic [31:0] got;
      hold_cycles = 10;
      tx_log.delete(); tx_cyc.delete();
      issue(1'b1, 4, 32'hDEADBEEF);
      wait_done(lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL out_latency got=%0d exp=5", lat); end
      for (t = 0; t < 200 && tx_log.size() < 4; t++) step();
      checks++;
      if (tx_log.size() !== 4) begin
         errors++; $display("FAIL out_bp_timeout got=%0d bytes exp=4", tx_log.size());
      end else begin
         got = {tx_log[3], tx_log[2], tx_log[1], tx_log[0]};
         checks += 2;
         if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL out_bp_bytes got=%h exp=deadbeef (LSB sent first)", got); end
         if (tx_cyc[1] - tx_cyc[0] !== 12 || tx_cyc[3] - tx_cyc[2] !== 12)
            begin errors++; $display("FAIL out_bp_spacing got=%0d,%0d exp=12", tx_cyc[1] - tx_cyc[0], tx_cyc[3] - tx_cyc[2]); end
      end
      repeat (15) step();
      checks += 2;
      if (tx_count !== 5'd0) begin errors++; $display("FAIL out_bp_tx_count got=%0d exp=0", tx_count); end
      if (rdata !== last_rdata) begin errors++; $display("FAIL out_rdata_kept got=%h exp=%h", rdata, last_rdata); end
   endtask

   task automatic test_out_random();
      int lat, nb, n, gap, t;
      logic [31:0] wd;
      for (int it = 0; it < 5; it++) begin
         nb = $urandom_range(0, 7);
         n  = eff_n(nb);
         wd = $urandom;
         hold_cycles = $urandom_range(0, 4);
         gap = (hold_cycles + 2 > 3) ? hold_cycles + 2 : 3;
         repeat (8) step();
         tx_log.delete(); tx_cyc.delete();
         issue(1'b1, nb, wd);
         wait_done(lat);
         checks++;
         if (lat !== n + 1) begin errors++; $display("FAIL outr_latency nb=%0d got=%0d exp=%0d", nb, lat, n + 1); end
         for (t = 0; t < 100 && tx_log.size() < n; t++) step();
         checks++;
         if (tx_log.size() !== n) begin
            errors++; $display("FAIL outr_timeout got=%0d bytes exp=%0d", tx_log.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (tx_log[i] !== 8'(wd >> (8 * i)))
                  begin errors++; $display("FAIL outr_byte%0d got=%h exp=%h", i, tx_log[i], 8'(wd >> (8 * i))); end
            end
            for (int i = 1; i < n; i++) begin
               checks++;
               if (tx_cyc[i] - tx_cyc[i-1] !== gap)
                  begin errors++; $display("FAIL outr_spacing hold=%0d got=%0d exp=%0d", hold_cycles, tx_cyc[i] - tx_cyc[i-1], gap); end
            end
         end
         checks++;
         if (rdata !== last_rdata) begin errors++; $display("FAIL outr_rdata_kept got=%h exp=%h", rdata, last_rdata); end
      end
   endtask

   task automatic test_tx_full();
      int bad = 0, t;
      logic found = 1'b0;
      logic [31:0] wd, got;
      wd = $urandom;
      d2_busy = 1'b1;
      d2_op = 1'b1; d2_nb = '0; d2_wd = wd; d2_valid = 1'b1;
      step();
      d2_valid = 1'b0; d2_wd = '0;
      for (int c = 0; c < 20; c++) begin
         if (d2_ready !== 1'b0 || d2_done !== 1'b0) bad++;
         step();
      end
      checks += 3;
      if (bad !== 0) begin errors++; $display("FAIL txfull_stall got=%0d bad cycles exp=0", bad); end
      if (d2_tx_count !== 2'd2) begin errors++; $display("FAIL txfull_count got=%0d exp=2", d2_tx_count); end
      if (tx2_log.size() !== 0) begin errors++; $display("FAIL txfull_sent_while_busy got=%0d exp=0", tx2_log.size()); end
      d2_busy = 1'b0;
      for (t = 0; t < 100; t++) begin
         if (d2_done) begin found = 1'b1; break; end
         step();
      end
      step();
      checks += 2;
      if (found !== 1'b1) begin errors++; $display("FAIL txfull_done got=none exp=pulse"); end
      if (d2_ready !== 1'b1) begin errors++; $display("FAIL txfull_ready_after got=%b exp=1", d2_ready); end
      for (t = 0; t < 100 && tx2_log.size() < 4; t++) step();
      checks++;
      if (tx2_log.size() !== 4) begin
         errors++; $display("FAIL txfull_timeout got=%0d bytes exp=4", tx2_log.size());
      end else begin
         got = {tx2_log[3], tx2_log[2], tx2_log[1], tx2_log[0]};
         checks++;
         if (got !== wd) begin errors++; $display("FAIL txfull_bytes got=%h exp=%h", got, wd); end
      end
      repeat (5) step();
      checks++;
      if (d2_tx_count !== 2'd0) begin errors++; $display("FAIL txfull_drained got=%0d exp=0", d2_tx_count); end
   endtask

   initial begin
      rstn = 1'b0;
      rx_data = '0; rx_valid = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
      cmd_nbytes = '0; cmd_wdata = '0; clr_ovf = 1'b0;
      d2_busy = 1'b0; d2_valid = 1'b0; d2_op = 1'b0; d2_nb = '0; d2_wd = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_in_4();
      test_in_late();
      test_in_random();
      test_overflow();
      test_out_backpressure();
      test_out_random();
      test_tx_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
